// File: rtl/btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchronizer, symmetric debounce, press/release
// strobes, debounced level, long-press and auto-repeat strobes, all sysclk-synchronous.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 300,
  parameter int LONG_PRESS_CYCLES = 62_500_000,
  parameter int REPEAT_CYCLES     = 12_500_000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse
);

  localparam int  DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int  HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int  HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam bit  REP_EN   = (REPEAT_CYCLES != 0);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_AT  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] REP_AT   = HOLD_W'(REPEAT_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("btn_conditioner: LONG_PRESS_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t            state;
  logic [1:0]        sync;
  logic              btn_s;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              long_done;

  assign btn_s    = sync[1];
  assign hold_nxt = hold_cnt + HOLD_W'(1);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync             <= '0;
      state            <= IDLE;
      deb_cnt          <= '0;
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
    end else begin
      sync             <= {sync[0], btn};
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= HELD;
            deb_cnt     <= '0;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        HELD: begin
          // Counter runs to the long-press point, then is reloaded to time each
          // repeat period; with repeat disabled it simply parks, so it never wraps.
          if (!long_done) begin
            if (hold_nxt == LONG_AT) begin
              long_press_pulse <= 1'b1;
              long_done        <= 1'b1;
              hold_cnt         <= '0;
            end else begin
              hold_cnt <= hold_nxt;
            end
          end else if (REP_EN) begin
            if (hold_nxt == REP_AT) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_nxt;
            end
          end
          if (!btn_s) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state   <= HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule
